hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
// - Multi-cycle sequencer and owner of the HI/LO register pair for the execute stage.
// - Runs MULT/MULTU/DIV/DIVU as 32 iterations, one iteration per clock, and handles MTHI/MTLO.
// - Stalls the pipeline when a HI/LO read or a new mul/div arrives while an operation is in flight.
// - Sits beside the EX-stage ALU; its hi/lo outputs feed the ALU output mux (MFHI/MFLO path).
// PARAMETERS
// - WIDTH  32  operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
// - clk       in   1      clock, rising edge
// - rst       in   1      asynchronous reset, active-low
// - start     in   1      EX holds a mul/div/mthi/mtlo op this cycle
// - op        in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 NOP
// - s_in      in   WIDTH  forwarded S operand (dividend / multiplicand / MT source)
// - t_in      in   WIDTH  forwarded T operand (divisor / multiplier)
// - hilo_rd   in   1      EX instruction reads HI or LO (MFHI/MFLO)
// - abort     in   1      flush: kill any in-flight operation
// - stall     out  1      hold IF/ID/EX this cycle
// - busy      out  1      operation in flight
// - done      out  1      1-cycle pulse: HI/LO were written by a mul/div
// - div0      out  1      1-cycle pulse: DIV/DIVU with t_in == 0 (op dropped)
// - hi        out  WIDTH  HI register
// - lo        out  WIDTH  LO register
// BEHAVIOUR
// - Reset (rst = 0, async): state IDLE; hi = lo = 0; count = 0; busy, done, div0 = 0.
//   Reset mid-operation discards the operation.
// - States: IDLE, RUN, FIX.
// - IDLE, start & !abort:
//   - MTHI/MTLO: write hi/lo from s_in at this edge; stay IDLE; no done.
//   - DIV/DIVU with t_in == 0: hi/lo unchanged; div0 = 1 next cycle; stay IDLE.
//   - Other MULT/MULTU/DIV/DIVU: latch |s|, |t| (signed ops) or raw operands (unsigned).
//     Latch result sign flags; count = 0; go to RUN.
//   - NOP ops are ignored. abort & start in IDLE: start is ignored.
// - RUN: one iteration per edge.
//   - Multiply: shift-add on a 2*WIDTH accumulator.
//   - Divide: restoring, one quotient bit per iteration.
//   - count increments; when count == WIDTH-1 go to FIX.
// - FIX: apply sign correction and write hi/lo at this edge.
//   - MULT: {hi,lo} = negated if s^t sign.
//   - DIV: lo = quotient, negated if s^t sign; hi = remainder, sign of dividend.
//   - Modulo-2^WIDTH wrap: DIV 0x80000000 / -1 gives lo = 0x80000000, hi = 0.
//   - done = 1 for the cycle after this edge; return to IDLE.
// - Latency: start edge E0, RUN edges E1..E32, FIX edge E33 writes hi/lo.
//   busy = 1 from after E0 through the cycle ending at E33.
// - stall = busy & (hilo_rd | start), combinational.
//   - start while busy is not accepted; the stalled instruction is re-presented.
//   - On the cycle done is high, hilo_rd sees the new values and does not stall.
// - abort in RUN/FIX: go to IDLE at the next edge; hi/lo unchanged; no done.
//   abort has priority over the FIX write.
// - done and div0 are never asserted together; stall never asserts in IDLE.
// STRUCTURE
// - Shared package muldiv_defs.vh:
//   - op encodings (OP_MULT..OP_MTLO)
//   - state encodings (ST_IDLE, ST_RUN, ST_FIX)
//   - ITER_W = clog2(WIDTH)
// - One sub-module, muldiv_step: combinational single-iteration datapath.
//   - Inputs: accumulator, operand, mode. Output: next accumulator.
//   - Counter, FSM, sign fix-up, HI/LO and stall logic stay in this module.
// TESTING
// - Reset asserted at RUN count 10 -> hi = lo = 0, busy = 0 immediately; no done.
// - MULT -1 * 7 -> done 34 cycles after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFF9.
// - MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001.
// - DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
//   DIVU 7 / 0 -> div0 pulse, hi/lo unchanged, busy stays 0.
// - DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
//   MTLO 0x1234 -> lo = 0x1234 next cycle, no stall.
// - hilo_rd held after a MULT start -> stall = 1 for 33 cycles, 0 in the done cycle.
//   abort at count 10 -> IDLE next cycle, hi/lo keep prior values, no done.

Source files
------------

// File: rtl/hilo_muldiv_ctrl_pkg.sv
// hilo_muldiv_ctrl_pkg: op/state encodings and sizing helper shared by the HI/LO sequencer
package hilo_muldiv_ctrl_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_e;
  function automatic int iter_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/hilo_muldiv_ctrl_step.sv
// hilo_muldiv_ctrl_step: one shift-add multiply or restoring-divide iteration
module hilo_muldiv_ctrl_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd & {WIDTH{acc[0]}}};
    trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opd};
    acc_nxt = !is_div ? {sum, acc[WIDTH-1:1]}
            : trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
            : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative mul/div sequencer owning HI/LO, with pipeline stall generation
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] t_in,
  input  logic             hilo_rd,
  input  logic             abort,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int IW = iter_w(WIDTH);
  state_e state_q, state_d;
  logic [IW-1:0] count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, p_fix;
  logic [WIDTH-1:0] opd_q, opd_d, hi_q, hi_d, lo_q, lo_d, s_abs, t_abs, q_fix, r_fix;
  logic is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
  logic done_q, done_d, div0_q, div0_d, sgn, is_md, is_dv, go;
  hilo_muldiv_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .acc    (acc_q),
    .opd    (opd_q),
    .is_div (is_div_q),
    .acc_nxt(acc_step)
  );
  always_comb begin
    sgn       = op == OP_MULT || op == OP_DIV;
    is_md     = op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    is_dv     = op inside {OP_DIV, OP_DIVU};
    go        = state_q == ST_IDLE && start && !abort;
    s_abs     = sgn && s_in[WIDTH-1] ? -s_in : s_in;
    t_abs     = sgn && t_in[WIDTH-1] ? -t_in : t_in;
    p_fix     = neg_q ? -acc_q : acc_q;
    q_fix     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_fix     = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (go && op == OP_MTHI) hi_d = s_in;
      if (go && op == OP_MTLO) lo_d = s_in;
      if (go && is_dv && t_in == '0) div0_d = 1'b1;
      else if (go && is_md) begin
        state_d   = ST_RUN;
        count_d   = '0;
        is_div_d  = is_dv;
        opd_d     = is_dv ? t_abs : s_abs;
        acc_d     = {{WIDTH{1'b0}}, is_dv ? s_abs : t_abs};
        neg_d     = sgn && (s_in[WIDTH-1] ^ t_in[WIDTH-1]);
        neg_rem_d = sgn && s_in[WIDTH-1];
      end
    end else if (abort) state_d = ST_IDLE;
    else if (state_q == ST_RUN) begin
      acc_d   = acc_step;
      count_d = count_q + 1'b1;
      state_d = count_q == IW'(WIDTH - 1) ? ST_FIX : ST_RUN;
    end else begin
      state_d      = ST_IDLE;
      done_d       = 1'b1;
      {hi_d, lo_d} = is_div_q ? {r_fix, q_fix} : p_fix;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end
  assign busy  = state_q != ST_IDLE;
  assign stall = busy & (hilo_rd | start);
  assign done  = done_q;
  assign div0  = div0_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: directed vectors checked against a transaction-level HI/LO model
module tb_hilo_muldiv_ctrl;
  logic clk = 0, rst = 1, start = 0, hilo_rd = 0, abort = 0;
  logic [2:0] op = 3'd6;
  logic [31:0] s_in = 0, t_in = 0;
  logic stall, busy, done, div0;
  logic [31:0] hi, lo;
  int total = 0, bad = 0;
  int m_rem = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic m_done = 0, m_div0 = 0;
  logic [63:0] m_res = 0;
  int lat, sc;
  logic seen;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .s_in(s_in), .t_in(t_in),
    .hilo_rd(hilo_rd), .abort(abort), .stall(stall), .busy(busy), .done(done),
    .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] s, input logic [31:0] t);
    longint a, b, q, r;
    logic [63:0] p;
    a = longint'($signed(s));
    b = longint'($signed(t));
    p = 0;
    case (o)
      3'd0: p = a * b;
      3'd1: p = {32'b0, s} * {32'b0, t};
      3'd2: begin q = a / b; r = a % b; p = {r[31:0], q[31:0]}; end
      default: p = {s % t, s / t};
    endcase
    return p;
  endfunction

  // Model: an accepted mul/div keeps the unit busy for 33 edges, then HI/LO take the result
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rem <= 0; m_hi <= 0; m_lo <= 0; m_done <= 0; m_div0 <= 0;
    end else begin
      m_done <= 0;
      m_div0 <= 0;
      if (m_rem > 0) begin
        if (abort) m_rem <= 0;
        else begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; m_done <= 1;
          end
        end
      end else if (start && !abort) begin
        if (op == 3'd4) m_hi <= s_in;
        else if (op == 3'd5) m_lo <= s_in;
        else if (op < 3'd4) begin
          if (op >= 3'd2 && t_in == 0) m_div0 <= 1;
          else begin m_res <= ref_res(op, s_in, t_in); m_rem <= 33; end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", busy, m_rem != 0);
    chk("stall", stall, (m_rem != 0) && (hilo_rd || start));
    chk("done", done, m_done);
    chk("div0", div0, m_div0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic run_md(input logic [2:0] o, input logic [31:0] s, input logic [31:0] t, output int n);
    op = o; s_in = s; t_in = t; start = 1;
    @(posedge clk); #1;
    start = 0; op = 3'd6; n = 1;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] s, input logic [31:0] t);
    op = o; s_in = s; t_in = t; start = 1;
    @(posedge clk); #1;
    start = 0; op = 3'd6;
  endtask

  initial begin
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_busy", busy, 0);
    run_md(3'd0, 32'hFFFFFFFF, 32'd7, lat);
    chk("mult_lat", lat, 34); chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFF9);
    run_md(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("multu_hi", hi, 32'hFFFFFFFE); chk("multu_lo", lo, 32'h00000001);
    run_md(3'd2, 32'hFFFFFFF9, 32'd2, lat);
    chk("div_lo", lo, 32'hFFFFFFFD); chk("div_hi", hi, 32'hFFFFFFFF);
    issue(3'd3, 32'd7, 32'd0);
    chk("div0_pulse", div0, 1); chk("div0_busy", busy, 0);
    chk("div0_hi", hi, 32'hFFFFFFFF); chk("div0_lo", lo, 32'hFFFFFFFD);
    @(posedge clk); #1;
    chk("div0_clear", div0, 0);
    run_md(3'd2, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("ovf_lo", lo, 32'h80000000); chk("ovf_hi", hi, 32'h0);
    op = 3'd5; s_in = 32'h1234; start = 1; #1;
    chk("mtlo_stall", stall, 0);
    @(posedge clk); #1; start = 0; op = 3'd6;
    chk("mtlo_lo", lo, 32'h1234); chk("mtlo_hi", hi, 0);
    issue(3'd4, 32'hABCD, 0);
    chk("mthi_hi", hi, 32'hABCD); chk("mthi_done", done, 0);
    issue(3'd0, 32'd3, 32'd5);
    hilo_rd = 1; sc = 0; lat = 0;
    while (!done && lat < 100) begin
      if (stall) sc++;
      @(posedge clk); #1; lat++;
    end
    chk("rd_stall_cnt", sc, 33); chk("rd_done", done, 1); chk("rd_done_stall", stall, 0);
    chk("rd_lo", lo, 32'd15); chk("rd_hi", hi, 0);
    hilo_rd = 0;
    issue(3'd0, 32'd2, 32'd2);
    repeat (10) begin @(posedge clk); #1; end
    abort = 1;
    @(posedge clk); #1; abort = 0;
    chk("abort_busy", busy, 0); chk("abort_hi", hi, 0); chk("abort_lo", lo, 32'd15);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1; end
    chk("abort_no_done", seen, 0);
    issue(3'd3, 32'd100, 32'd7);
    repeat (10) begin @(posedge clk); #1; end
    rst = 0; #1;
    chk("arst_busy", busy, 0); chk("arst_hi", hi, 0); chk("arst_lo", lo, 0); chk("arst_done", done, 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    run_md(3'd1, 32'h10000, 32'h10000, lat);
    chk("post_lat", lat, 34); chk("post_hi", hi, 32'd1); chk("post_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
